// File: rtl/alarm_ctrl_fsm.sv
// alarm_ctrl_fsm: decodes keypad and buttons into display-select and register-load strobes
module alarm_ctrl_fsm #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY       = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count
);
    typedef enum logic [2:0] {SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM} state_t;
    state_t     state, next;
    logic [3:0] tcnt;
    logic       valid_key, timeout;
    assign valid_key = key != NOKEY && key <= 4'd9;
    assign timeout   = tcnt == 4'(TIMEOUT_SEC);
    // tcnt restarts on every stored key so each digit gets a full timeout window
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHOW_TIME;
            tcnt  <= '0;
        end else begin
            state <= next;
            if (state inside {SHOW_TIME, SHOW_ALARM, KEY_STORED}) tcnt <= '0;
            else if (one_second && !timeout) tcnt <= tcnt + 4'd1;
        end
    end
    always_comb begin
        next = state;
        case (state)
            SHOW_TIME:  next = alarm_button ? SHOW_ALARM : valid_key ? KEY_STORED : SHOW_TIME;
            KEY_STORED: next = KEY_WAITED;
            KEY_WAITED: next = !valid_key ? KEY_ENTRY : timeout ? SHOW_TIME : KEY_WAITED;
            KEY_ENTRY:  next = (alarm_button || time_button || timeout) ? SHOW_TIME
                             : valid_key ? KEY_STORED : KEY_ENTRY;
            SHOW_ALARM: next = alarm_button ? SHOW_ALARM : SHOW_TIME;
            default:    next = SHOW_TIME;
        endcase
    end
    always_comb begin
        show_new_time = state inside {KEY_STORED, KEY_WAITED, KEY_ENTRY};
        show_alarm    = state == SHOW_ALARM;
        shift         = state == KEY_STORED;
        load_new_a    = state == KEY_ENTRY && alarm_button;
        load_new_c    = state == KEY_ENTRY && time_button && !alarm_button;
        reset_count   = load_new_c;
    end
endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// tb_alarm_ctrl_fsm: directed and random checks of alarm_ctrl_fsm against an entry-session model
module tb_alarm_ctrl_fsm;
    localparam int T = 10;
    logic       clock = 0, reset = 1, one_second = 0, alarm_button = 0, time_button = 0;
    logic [3:0] key = 4'd10;
    logic       show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count;
    int         checks = 0, errors = 0, shifts = 0;
    bit         m_alarm, m_entering, m_pending, m_waiting;
    int         m_secs;
    logic       snt_seen, la_seen, lc_seen, rc_seen;

    always #5 clock = ~clock;

    alarm_ctrl_fsm #(.TIMEOUT_SEC(T), .NOKEY(4'd10)) dut (
        .clock(clock), .reset(reset), .one_second(one_second), .key(key),
        .alarm_button(alarm_button), .time_button(time_button),
        .show_new_time(show_new_time), .show_alarm(show_alarm), .shift(shift),
        .load_new_a(load_new_a), .load_new_c(load_new_c), .reset_count(reset_count)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_alarm = 0; m_entering = 0; m_pending = 0; m_waiting = 0; m_secs = 0;
    endfunction

    // Session view: an entry is open, a fresh key is pending a shift, or we wait for release
    task automatic check_all(input string tag);
        bit idle;
        idle = m_entering && !m_pending && !m_waiting;
        chk({tag, ".show_new_time"}, show_new_time, m_entering);
        chk({tag, ".show_alarm"}, show_alarm, m_alarm);
        chk({tag, ".shift"}, shift, m_pending);
        chk({tag, ".load_new_a"}, load_new_a, idle && alarm_button);
        chk({tag, ".load_new_c"}, load_new_c, idle && time_button && !alarm_button);
        chk({tag, ".reset_count"}, reset_count, idle && time_button && !alarm_button);
        snt_seen = show_new_time; la_seen = load_new_a; lc_seen = load_new_c; rc_seen = reset_count;
        if (shift === 1'b1) shifts++;
    endtask

    function automatic void model_step();
        bit valid, expired;
        valid   = key <= 4'd9;
        expired = m_secs >= T;
        if (m_alarm) m_alarm = alarm_button;
        else if (!m_entering) begin
            if (alarm_button) m_alarm = 1;
            else if (valid) begin m_entering = 1; m_pending = 1; m_secs = 0; end
        end else if (m_pending) begin
            m_pending = 0; m_waiting = 1; m_secs = 0;
        end else begin
            if (m_waiting) begin
                if (!valid) m_waiting = 0;
                else if (expired) begin m_entering = 0; m_waiting = 0; end
            end else if (alarm_button || time_button || expired) m_entering = 0;
            else if (valid) m_pending = 1;
            if (one_second && m_secs < T) m_secs++;
        end
    endfunction

    task automatic cyc(input logic a, input logic t, input logic [3:0] k, input logic tick, input string tag);
        alarm_button = a; time_button = t; key = k; one_second = tick;
        @(negedge clock);
        check_all(tag);
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    initial begin
        logic [3:0] rk;
        model_reset();
        #1;
        check_all("reset");
        cyc(0, 0, 4'd5, 1, "reset_hold");
        reset = 0;
        // single digit entry
        shifts = 0;
        repeat (3) cyc(0, 0, 4'd5, 0, "digit5");
        repeat (2) cyc(0, 0, 4'd10, 0, "digit5_rel");
        chk_int("digit5.shifts", shifts, 1);
        chk("digit5.in_entry", snt_seen, 1'b1);
        // set time with digits 1..4
        shifts = 0;
        for (int d = 1; d <= 4; d++) begin
            repeat (2) cyc(0, 0, 4'(d), 0, "set_time.key");
            repeat (2) cyc(0, 0, 4'd15, 0, "set_time.rel");
        end
        cyc(0, 1, 4'd10, 0, "set_time.btn");
        chk("set_time.load_c", lc_seen, 1'b1);
        chk("set_time.reset_count", rc_seen, 1'b1);
        chk("set_time.load_a", la_seen, 1'b0);
        chk_int("set_time.shifts", shifts, 4);
        cyc(0, 0, 4'd10, 0, "set_time.after");
        chk("set_time.snt_after", snt_seen, 1'b0);
        // both buttons: alarm wins
        repeat (2) cyc(0, 0, 4'd8, 0, "both.key");
        cyc(0, 0, 4'd10, 0, "both.rel");
        cyc(1, 1, 4'd10, 0, "both.btn");
        chk("both.load_a", la_seen, 1'b1);
        chk("both.load_c", lc_seen, 1'b0);
        cyc(0, 0, 4'd10, 0, "both.after");
        chk("both.snt_after", snt_seen, 1'b0);
        // timeout after 10 ticks
        cyc(0, 0, 4'd7, 0, "to.key");
        cyc(0, 0, 4'd10, 0, "to.rel");
        repeat (T) cyc(0, 0, 4'd10, 1, "to.tick");
        cyc(0, 0, 4'd10, 0, "to.edge");
        chk("to.still_entry", snt_seen, 1'b1);
        cyc(0, 0, 4'd10, 0, "to.done");
        chk("to.expired", snt_seen, 1'b0);
        // new key after 9th tick restarts the timeout
        cyc(0, 0, 4'd7, 0, "rst_to.key");
        cyc(0, 0, 4'd10, 0, "rst_to.rel");
        repeat (T - 1) cyc(0, 0, 4'd10, 1, "rst_to.tick");
        cyc(0, 0, 4'd2, 0, "rst_to.key2");
        cyc(0, 0, 4'd10, 1, "rst_to.stored_tick");
        cyc(0, 0, 4'd10, 1, "rst_to.tick10");
        repeat (2) cyc(0, 0, 4'd10, 0, "rst_to.idle");
        chk("rst_to.no_timeout", snt_seen, 1'b1);
        cyc(0, 1, 4'd10, 0, "rst_to.close");
        // show alarm with key pressed during hold
        shifts = 0;
        repeat (2) cyc(1, 0, 4'd10, 0, "alarm.hold");
        repeat (3) cyc(1, 1, 4'd3, 0, "alarm.hold_key");
        cyc(0, 0, 4'd10, 0, "alarm.release");
        cyc(0, 0, 4'd10, 0, "alarm.after");
        chk_int("alarm.shifts", shifts, 0);
        // async reset mid entry with alarm_button held
        cyc(0, 0, 4'd4, 0, "ar.key");
        cyc(0, 0, 4'd10, 1, "ar.rel");
        cyc(0, 0, 4'd10, 1, "ar.tick");
        alarm_button = 1;
        #1;
        chk("ar.pre_load_a", load_new_a, 1'b1);
        reset = 1;
        #1;
        chk("ar.show_new_time", show_new_time, 1'b0);
        chk("ar.load_a", load_new_a, 1'b0);
        chk("ar.shift", shift, 1'b0);
        chk("ar.show_alarm", show_alarm, 1'b0);
        chk_int("ar.tcnt", int'(dut.tcnt), 0);
        model_reset();
        cyc(1, 1, 4'd6, 1, "ar.held");
        reset = 0;
        cyc(0, 0, 4'd10, 0, "ar.after");
        // random traffic
        rk = 4'd10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rk = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0, rk,
                $urandom_range(0, 2) == 0, "rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alarm_ctrl_fsm.md
Name: alarm_ctrl_fsm

Overview:
- Control FSM for the alarm clock; sits directly upstream of the LCD display stage.
- Decodes keypad and button activity into mode strobes: `show_new_time`, `show_alarm`, `shift`, `load_new_a`, `load_new_c`, `reset_count`.
- These strobes select what the display shows and load the alarm and time registers.
- Implements a timeout that abandons key entry after `TIMEOUT_SEC` seconds of inactivity.

Parameters:
- `TIMEOUT_SEC`, 10: number of `one_second` pulses of inactivity before key entry is abandoned; range 1..15.
- `NOKEY`, 4'd10: key code meaning "no key pressed". Codes 0-9 are digits; 11-15 are ignored and treated as `NOKEY`.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `one_second`  in  1  single-cycle tick, once per second, synchronous to `clock`.
- `key`  in  4  keypad code; 0-9 is a digit, anything else is no key.
- `alarm_button`  in  1  level; high while the alarm button is held.
- `time_button`  in  1  level; high while the time button is held.
- `show_new_time`  out  1  display shows the key buffer (drives the display's `show_new_time`).
- `show_alarm`  out  1  display shows the alarm time.
- `shift`  out  1  one-cycle strobe: shift the current key into the key buffer.
- `load_new_a`  out  1  one-cycle strobe: load the key buffer into the alarm register.
- `load_new_c`  out  1  one-cycle strobe: load the key buffer into the current-time counter.
- `reset_count`  out  1  one-cycle strobe: clear the seconds prescaler; equals `load_new_c`.

Behaviour:
- **Reset.**
  - Asserting `reset` immediately forces state `SHOW_TIME` and clears the timeout counter `tcnt` to 0, regardless of `clock`.
  - All outputs read 0 while in reset.
  - Reset mid-entry discards the entry; no load strobe is generated.
- **States.** Five states, binary encoded: `SHOW_TIME`, `KEY_STORED`, `KEY_WAITED`, `KEY_ENTRY`, `SHOW_ALARM`.
- **Transitions** (evaluated each rising edge; `valid_key` = key ≤ 9; `timeout` = (tcnt == TIMEOUT_SEC)):
  - `SHOW_TIME`:
    - `alarm_button` -> `SHOW_ALARM`
    - else `valid_key` -> `KEY_STORED`
    - else stay.
  - `KEY_STORED`: always -> `KEY_WAITED`. This state lasts exactly 1 cycle.
  - `KEY_WAITED`:
    - `!valid_key` (key released) -> `KEY_ENTRY`
    - else `timeout` -> `SHOW_TIME`
    - else stay.
  - `KEY_ENTRY`, in priority order:
    - `alarm_button` -> `SHOW_TIME`
    - `time_button` -> `SHOW_TIME`
    - `timeout` -> `SHOW_TIME`
    - `valid_key` -> `KEY_STORED`
    - else stay.
  - `SHOW_ALARM`: `!alarm_button` -> `SHOW_TIME`; else stay.
- **Outputs** (combinational from state and inputs; no added latency):
  - `show_new_time` = state in {`KEY_STORED`, `KEY_WAITED`, `KEY_ENTRY`}
  - `show_alarm` = (state == `SHOW_ALARM`)
  - `shift` = (state == `KEY_STORED`); exactly one pulse per accepted key press.
  - `load_new_a` = (state == `KEY_ENTRY`) & `alarm_button`
  - `load_new_c` = (state == `KEY_ENTRY`) & `time_button` & `!alarm_button`
  - `reset_count` = `load_new_c`
  - `show_new_time` and `show_alarm` are never high together.
  - `load_new_a` and `load_new_c` are mutually exclusive; `alarm_button` wins when both buttons are pressed.
- **Timeout counter** (`tcnt`, 4 bits):
  - Cleared to 0 whenever state is `SHOW_TIME`, `SHOW_ALARM` or `KEY_STORED`, so each new key restarts the timeout.
  - In `KEY_WAITED` / `KEY_ENTRY`, increments on `one_second` and saturates at `TIMEOUT_SEC`; it never wraps.
  - Timeout takes effect on the edge after `tcnt` reaches `TIMEOUT_SEC`.
  - A `one_second` tick coinciding with `KEY_STORED` is ignored.
- **Held keys.**
  - A key held down produces only one `shift`: the FSM waits in `KEY_WAITED` until release.
  - A key held for `TIMEOUT_SEC` seconds aborts entry with no load strobe.
- **Buttons.**
  - Buttons pressed in `KEY_STORED` / `KEY_WAITED` are ignored.
  - `time_button` in `SHOW_TIME` / `SHOW_ALARM` has no effect.
- Invalid key codes 11-15 behave exactly like `NOKEY`.

Test Plan:
- **Reset values.** Assert `reset` mid-cycle while in `KEY_ENTRY` -> state returns to `SHOW_TIME` asynchronously; all outputs 0; `tcnt` = 0.
- **Single digit entry.** From `SHOW_TIME`, key=5 for 3 cycles then key=10 ->
  - `shift` high exactly 1 cycle, in the cycle after key=5 is sampled;
  - `show_new_time` high from that cycle onward;
  - state `KEY_ENTRY` after release.
- **Set time.** Enter digits 1,2,3,4 (each held 2 cycles, released 2 cycles), then `time_button`=1 for 1 cycle ->
  - exactly 4 `shift` pulses;
  - `load_new_c` = `reset_count` = 1 for that cycle;
  - `load_new_a`=0;
  - next state `SHOW_TIME`; `show_new_time`=0.
- **Set alarm, both buttons.** In `KEY_ENTRY` assert `alarm_button` and `time_button` together -> `load_new_a`=1, `load_new_c`=0, next state `SHOW_TIME`.
- **Timeout.** `TIMEOUT_SEC`=10; enter key 7 then release, apply 10 `one_second` ticks ->
  - return to `SHOW_TIME` on the edge after the 10th tick;
  - no load strobe.
  - Repeat with a new key after the 9th tick -> `tcnt` restarts and no timeout occurs at tick 10.
- **Show alarm.** Hold `alarm_button` 5 cycles in `SHOW_TIME` -> `show_alarm`=1 for the held cycles, `show_new_time`=0; drops to 0 one cycle after release. A key=3 during the hold produces no `shift`.
